pipe_skid_reg: RTL and testbench

//  Parametrised pipeline-stage register: successor to the plain enable-mux 64-bit register.

---
 rtl/pipe_skid_reg.sv | 51 +++++
 tb/tb_pipe_skid_reg.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline register with 1-entry skid buffer, sync flush, async active-low reset, optional stall counter (PIPE_SKID_REG_STALL_CNT_EN); ports clk reset in_valid/in_ready/in_data -> out_valid/out_ready/out_data, flush, stall_cnt
module pipe_skid_reg #(
  parameter int WIDTH = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [31:0]      stall_cnt
);
  logic main_v, skid_v, acc, adv;
  logic [WIDTH-1:0] main_d, skid_d;
  assign in_ready  = ~skid_v;
  assign out_valid = main_v;
  assign out_data  = main_d;
  assign acc = in_valid & ~skid_v;
  assign adv = out_ready | ~main_v;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= RESET_VAL;
      skid_d <= RESET_VAL;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (adv) begin
      main_v <= skid_v | acc;
      skid_v <= 1'b0;
      if (skid_v) main_d <= skid_d;
      else if (acc) main_d <= in_data;
    end else if (acc) begin
      skid_d <= in_data;
      skid_v <= 1'b1;
    end
`ifdef PIPE_SKID_REG_STALL_CNT_EN
  logic [31:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (main_v & ~out_ready & ~&cnt) cnt <= cnt + 32'd1;
  assign stall_cnt = cnt;
`else
  assign stall_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: queue-model self-checking bench for pipe_skid_reg (WIDTH=8, RESET_VAL=8'h5A)
module tb_pipe_skid_reg;
  localparam int W = 8;
  localparam logic [W-1:0] RV = 8'h5A;
  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [31:0] stall_cnt;
  int ntot = 0, nbad = 0;
  logic [W-1:0] mq[$], sent[$], got[$];
  logic [W-1:0] od = RV;
  logic [31:0] mcnt = '0;
  pipe_skid_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .flush(flush),
    .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] exp_cnt(input logic [31:0] c);
`ifdef PIPE_SKID_REG_STALL_CNT_EN
    return c;
`else
    return 32'h0;
`endif
  endfunction
  task automatic model_reset();
    mq.delete();
    od = RV;
    mcnt = '0;
  endtask
  task automatic model_edge();
    bit ir, pop, take;
    ir = mq.size() < 2;
    pop = mq.size() > 0 && out_ready;
    take = in_valid && ir;
    if (mq.size() > 0 && !out_ready && mcnt != 32'hFFFF_FFFF) mcnt++;
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (take) begin
        mq.push_back(in_data);
        sent.push_back(in_data);
      end
    end
    if (mq.size() > 0) od = mq[0];
  endtask
  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    in_valid = v;
    in_data = d;
    out_ready = r;
    flush = f;
    #1;
    if (out_valid && out_ready && !flush) got.push_back(out_data);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask
  always @(negedge clk)
    if (reset) begin
      chk("out_valid", out_valid, mq.size() > 0);
      chk("in_ready", in_ready, mq.size() < 2);
      if (out_valid) chk("out_data", out_data, od);
      chk("stall_cnt", stall_cnt, exp_cnt(mcnt));
    end
  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask
  initial begin
    logic [W-1:0] seq;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, RV);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_stall_cnt", stall_cnt, 32'h0);
    reset = 1'b1;
    drive(1'b1, 8'h01, 1'b1, 1'b0);
    chk("t2_d1", out_data, 8'h01);
    drive(1'b1, 8'h02, 1'b1, 1'b0);
    chk("t2_d2", out_data, 8'h02);
    chk("t2_rdy", in_ready, 1'b1);
    drive(1'b1, 8'h03, 1'b1, 1'b0);
    chk("t2_d3", out_data, 8'h03);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t2_empty", out_valid, 1'b0);
    drive(1'b1, 8'h0A, 1'b0, 1'b0);
    drive(1'b1, 8'h0B, 1'b0, 1'b0);
    chk("t3_rdy0", in_ready, 1'b0);
    chk("t3_hold", out_data, 8'h0A);
    drive(1'b1, 8'h0B, 1'b0, 1'b0);
    chk("t3_hold2", out_data, 8'h0A);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_b", out_data, 8'h0B);
    chk("t3_rdy1", in_ready, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_empty", out_valid, 1'b0);
    drive(1'b1, 8'h0A, 1'b0, 1'b0);
    drive(1'b1, 8'h0B, 1'b0, 1'b0);
    drive(1'b1, 8'h0C, 1'b1, 1'b1);
    chk("t4_v", out_valid, 1'b0);
    chk("t4_rdy", in_ready, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_noc", out_valid, 1'b0);
    do_reset();
    drive(1'b1, 8'h07, 1'b0, 1'b0);
    repeat (5) drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t5_cnt", stall_cnt, exp_cnt(32'd5));
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t5_flush_keeps", stall_cnt, exp_cnt(32'd6));
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("t1_v", out_valid, 1'b0);
    chk("t1_d", out_data, RV);
    chk("t1_rdy", in_ready, 1'b1);
    chk("t1_cnt", stall_cnt, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    sent.delete();
    got.delete();
    seq = 8'h00;
    for (int i = 0; i < 10000; i++) begin
      logic v, r, a;
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 3) != 0);
      a = v && in_ready;
      drive(v, seq, r, 1'b0);
      if (a) seq++;
    end
    repeat (4) drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t6_count", got.size(), sent.size());
    begin
      int bad = 0;
      for (int i = 0; i < got.size() && i < sent.size(); i++)
        if (got[i] !== sent[i]) bad++;
      chk("t6_order", bad, 0);
    end
    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end
endmodule
